// File: rtl/diag_loop_chain_ctrl_if.sv
// Beat handshake between the row-fault-flag source and the diagnosis controller.
// One beat carries one row of per-column PE fault flags.
interface diag_loop_chain_ctrl_if #(
   parameter int COLS = 8
) ();
   logic            col_valid;
   logic [COLS-1:0] col_inputs;
   logic            col_ready;

   modport master (
      output col_valid,
      output col_inputs,
      input  col_ready
   );

   modport slave (
      input  col_valid,
      input  col_inputs,
      output col_ready
   );
endinterface

// File: rtl/diag_loop_chain_ctrl.sv
// Systolic-array fault diagnosis using one recirculating loop chain per column.
// Optional popcount output fault_count is built when DIAG_FAULT_COUNT_EN is defined.
module diag_loop_chain_ctrl #(
   parameter int ROWS    = 8,
   parameter int COLS    = 8,
   parameter int RUN_LEN = 3,
   parameter int PASSES  = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   diag_loop_chain_ctrl_if.slave     col_if,
   output logic                      busy,
   output logic                      done,
   output logic [$clog2(ROWS)-1:0]   row_idx,
   output logic [COLS-1:0]           single_pe_detection,
   output logic [ROWS-1:0]           row_fault_detection,
   output logic [COLS-1:0]           column_fault_detection
`ifdef DIAG_FAULT_COUNT_EN
   ,
   output logic [$clog2(ROWS*COLS+1)-1:0] fault_count
`endif
);
   localparam int RW    = $clog2(ROWS);
   localparam int TOTAL = PASSES * ROWS;
   localparam int CW    = $clog2(TOTAL + 1);
`ifdef DIAG_FAULT_COUNT_EN
   localparam int FW    = $clog2(ROWS * COLS + 1);
`endif

   typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [COLS-1:0] stage     [ROWS];
   logic [COLS-1:0] stage_nxt [ROWS];
   logic [CW-1:0]   beat_cnt;
   logic            accept;
   logic            last_beat;
   logic            wipe;
   logic            row_run;
   logic [COLS-1:0] col_run;
`ifdef DIAG_FAULT_COUNT_EN
   logic [FW-1:0]   pop;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (1'b1)
         state == IDLE:  if (start) state_nxt = CLEAR;
         state == CLEAR: state_nxt = abort ? IDLE : SCAN;
         state == SCAN: begin
            if (abort)          state_nxt = IDLE;
            else if (last_beat) state_nxt = DONE;
         end
         state == DONE:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy             = (state == CLEAR) || (state == SCAN);
      done             = (state == DONE);
      col_if.col_ready = (state == SCAN) && !abort;
   end

   assign accept    = col_if.col_valid && col_if.col_ready;
   assign last_beat = accept && (beat_cnt == CW'(TOTAL - 1));
   assign wipe      = (state == CLEAR) || (busy && abort);

   assign single_pe_detection = col_if.col_inputs | stage[ROWS-1];

   always_comb begin
      stage_nxt[0] = single_pe_detection;
      for (int k = 1; k < ROWS; k++) stage_nxt[k] = stage[k-1];
   end

   always_comb begin
      row_run = 1'b0;
      for (int i = 0; i <= COLS - RUN_LEN; i++)
         if (&single_pe_detection[i +: RUN_LEN]) row_run = 1'b1;
   end

   // column runs are judged on the loop as it will look after this beat
   always_comb begin
      logic run;
      run     = 1'b0;
      col_run = '0;
      for (int c = 0; c < COLS; c++) begin
         for (int i = 0; i <= ROWS - RUN_LEN; i++) begin
            run = 1'b1;
            for (int j = 0; j < RUN_LEN; j++) run = run & stage_nxt[i+j][c];
            if (run) col_run[c] = 1'b1;
         end
      end
   end

`ifdef DIAG_FAULT_COUNT_EN
   always_comb begin
      pop = '0;
      for (int k = 0; k < ROWS; k++)
         for (int c = 0; c < COLS; c++) pop = pop + FW'(stage_nxt[k][c]);
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < ROWS; k++) stage[k] <= '0;
         row_idx                <= '0;
         beat_cnt               <= '0;
         row_fault_detection    <= '0;
         column_fault_detection <= '0;
`ifdef DIAG_FAULT_COUNT_EN
         fault_count            <= '0;
`endif
      end else if (wipe) begin
         for (int k = 0; k < ROWS; k++) stage[k] <= '0;
         row_idx                <= '0;
         beat_cnt               <= '0;
         row_fault_detection    <= '0;
         column_fault_detection <= '0;
`ifdef DIAG_FAULT_COUNT_EN
         fault_count            <= '0;
`endif
      end else if (accept) begin
         for (int k = 0; k < ROWS; k++) stage[k] <= stage_nxt[k];
         row_idx <= (row_idx == RW'(ROWS - 1)) ? '0 : row_idx + RW'(1);
         if (beat_cnt != CW'(TOTAL)) beat_cnt <= beat_cnt + CW'(1);
         if (row_run) row_fault_detection[row_idx] <= 1'b1;
         if (last_beat) begin
            column_fault_detection <= col_run;
`ifdef DIAG_FAULT_COUNT_EN
            fault_count            <= pop;
`endif
         end
      end
   end
endmodule

// File: tb/tb_diag_loop_chain_ctrl.sv
// Randomized bench for diag_loop_chain_ctrl against a beat-history reference model.
// Covers clean, row-fault, column-fault, stall, abort and mid-scan reset runs.
module tb_diag_loop_chain_ctrl;
   localparam int ROWS    = 8;
   localparam int COLS    = 8;
   localparam int RUN_LEN = 3;
   localparam int PASSES  = 1;
   localparam int N       = ROWS * PASSES;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       busy;
   logic       done;
   logic [2:0] row_idx;
   logic [7:0] spd;
   logic [7:0] rfd;
   logic [7:0] cfd;
`ifdef DIAG_FAULT_COUNT_EN
   logic [6:0] fault_count;
`endif

   diag_loop_chain_ctrl_if #(.COLS(COLS)) col_if ();

   diag_loop_chain_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .RUN_LEN(RUN_LEN), .PASSES(PASSES)
   ) dut (
      .clk                    (clk),
      .rst_n                  (rst_n),
      .start                  (start),
      .abort                  (abort),
      .col_if                 (col_if),
      .busy                   (busy),
      .done                   (done),
      .row_idx                (row_idx),
      .single_pe_detection    (spd),
      .row_fault_detection    (rfd),
      .column_fault_detection (cfd)
`ifdef DIAG_FAULT_COUNT_EN
      ,
      .fault_count            (fault_count)
`endif
   );

   always #5 clk = ~clk;

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] beats [N];
   logic [7:0] eff   [N];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic bit has_run(input logic [7:0] v);
      int r = 0;
      for (int i = 0; i < 8; i++) begin
         r = v[i] ? r + 1 : 0;
         if (r >= RUN_LEN) return 1'b1;
      end
      return 1'b0;
   endfunction

   // effective beat = input OR what entered the loop one revolution earlier
   task automatic model(output logic [7:0] rf, output logic [7:0] cf,
                        output int fc);
      logic [7:0] v;
      rf = '0;
      cf = '0;
      fc = 0;
      for (int n = 0; n < N; n++) begin
         eff[n] = beats[n] | ((n >= ROWS) ? eff[n-ROWS] : 8'h00);
         if (has_run(eff[n])) rf[n % ROWS] = 1'b1;
      end
      for (int c = 0; c < COLS; c++) begin
         for (int k = 0; k < ROWS; k++) v[k] = eff[N-1-k][c];
         cf[c] = has_run(v);
      end
      for (int k = 0; k < ROWS; k++) fc += $countones(eff[N-1-k]);
   endtask

   // mode 0: full run, 1: abort at beat stop_at, 2: reset at beat stop_at
   task automatic run(input int mode, input int stop_at, input int stall_pct,
                      input int stall_at);
      logic [7:0] rf;
      logic [7:0] cf;
      int         fc;
      int         n = 0;
      int         guard = 0;
      int         stall_left = 0;
      model(rf, cf, fc);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      while (n < N && guard < 400) begin
         @(negedge clk);
         guard++;
         chk("row_idx", row_idx, 32'(n % ROWS));
         if (mode != 0 && n == stop_at) break;
         if (n == stall_at) begin
            stall_left = 3;
            stall_at   = -1;
         end
         col_if.col_valid  = (stall_left == 0) &&
                             ($urandom_range(99) >= stall_pct);
         if (stall_left > 0) stall_left--;
         col_if.col_inputs = beats[n];
         start             = (n == 3);
         #1;
         if (col_if.col_valid && col_if.col_ready) begin
            chk("single_pe", spd, eff[n]);
            n++;
         end
      end
      start = 1'b0;
      if (guard >= 400) chk("timeout", 1, 0);
      if (mode == 0) begin
         @(negedge clk) col_if.col_valid = 1'b0;
         chk("done", done, 1);
         chk("busy_done", busy, 0);
         chk("row_fault", rfd, rf);
         chk("col_fault", cfd, cf);
         chk("row_idx_end", row_idx, 0);
`ifdef DIAG_FAULT_COUNT_EN
         chk("fault_count", fault_count, 32'(fc));
`endif
         @(negedge clk);
         chk("done_pulse", done, 0);
         chk("row_fault_hold", rfd, rf);
         chk("col_fault_hold", cfd, cf);
      end else if (mode == 1) begin
         col_if.col_valid  = 1'b1;
         col_if.col_inputs = beats[n];
         abort             = 1'b1;
         #1 chk("ready_abort", col_if.col_ready, 0);
         @(negedge clk);
         abort = 1'b0;
         col_if.col_valid = 1'b0;
         chk("busy_abort", busy, 0);
         chk("row_fault_abort", rfd, 0);
         chk("col_fault_abort", cfd, 0);
         chk("row_idx_abort", row_idx, 0);
         repeat (3) begin
            chk("no_done_abort", done, 0);
            @(negedge clk);
         end
      end else begin
         col_if.col_inputs = 8'h5A;
         rst_n = 1'b0;
         #1;
         chk("busy_rst", busy, 0);
         chk("done_rst", done, 0);
         chk("row_idx_rst", row_idx, 0);
         chk("row_fault_rst", rfd, 0);
         chk("col_fault_rst", cfd, 0);
         chk("ready_rst", col_if.col_ready, 0);
         chk("single_pe_rst", spd, 8'h5A);
`ifdef DIAG_FAULT_COUNT_EN
         chk("fault_count_rst", fault_count, 0);
`endif
         @(negedge clk) rst_n = 1'b1;
         col_if.col_valid = 1'b0;
      end
   endtask

   task automatic zero_beats();
      for (int i = 0; i < N; i++) beats[i] = 8'h00;
   endtask

   initial begin
      col_if.col_valid  = 1'b0;
      col_if.col_inputs = 8'h00;
      repeat (2) @(negedge clk);
      chk("busy_init", busy, 0);
      chk("done_init", done, 0);
      chk("row_idx_init", row_idx, 0);
      chk("row_fault_init", rfd, 0);
      chk("col_fault_init", cfd, 0);
      chk("ready_init", col_if.col_ready, 0);
      col_if.col_inputs = 8'hA5;
      #1 chk("single_pe_init", spd, 8'hA5);
      col_if.col_inputs = 8'h00;
      @(negedge clk) rst_n = 1'b1;

      zero_beats();
      run(0, 0, 0, -1);
      zero_beats();
      beats[5] = 8'h38;
      run(0, 0, 0, -1);
      zero_beats();
      beats[2] = 8'h01;
      beats[3] = 8'h01;
      beats[4] = 8'h01;
      run(0, 0, 0, -1);
      zero_beats();
      beats[2] = 8'h01;
      beats[4] = 8'h01;
      run(0, 0, 0, -1);
      zero_beats();
      beats[1] = 8'h07;
      beats[2] = 8'h80;
      run(1, 6, 0, 3);
      zero_beats();
      beats[0] = 8'h0E;
      run(2, 4, 0, -1);
      for (int t = 0; t < 20; t++) begin
         for (int i = 0; i < N; i++) beats[i] = 8'($urandom & $urandom);
         run(0, 0, 25, $urandom_range(0, N - 1));
      end
      for (int i = 0; i < N; i++) beats[i] = 8'($urandom);
      run(1, $urandom_range(1, N - 1), 20, -1);
      zero_beats();
      run(0, 0, 10, -1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/diag_loop_chain_ctrl.md
DIAG_LOOP_CHAIN_CTRL -- requirements
Module: diag_loop_chain_ctrl

Interface
REQ-001 SHALL have parameter ROWS, default 8, meaning systolic rows and loop depth per column (>=3).
REQ-002 SHALL have parameter COLS, default 8, meaning systolic columns and number of loop chains (>=3).
REQ-003 SHALL have parameter RUN_LEN, default 3, meaning adjacent-fault run length for row/column fault (2..min(ROWS,COLS)).
REQ-004 SHALL have parameter PASSES, default 1, meaning full loop revolutions per diagnosis (>=1).
REQ-005 SHALL have port clk, input, 1 bit, meaning clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous, active-low.
REQ-007 SHALL have port start, input, 1 bit, meaning one-cycle request to begin a diagnosis.
REQ-008 SHALL have port abort, input, 1 bit, meaning cancel an active diagnosis.
REQ-009 SHALL have port col_valid, input, 1 bit, meaning col_inputs holds one row's PE fault flags.
REQ-010 SHALL have port col_inputs, input, COLS bits, meaning per-column fault flag of the current row.
REQ-011 SHALL have port col_ready, output, 1 bit, meaning a beat is accepted this cycle.
REQ-012 SHALL have port busy, output, 1 bit, meaning FSM is in CLEAR or SCAN.
REQ-013 SHALL have port done, output, 1 bit, meaning one-cycle pulse when the results are valid.
REQ-014 SHALL have port row_idx, output, clog2(ROWS) bits, meaning row address for the next beat (BIST/eNVM read address).
REQ-015 SHALL have port single_pe_detection, output, COLS bits, meaning col_inputs OR loop tail, combinational.
REQ-016 SHALL have port row_fault_detection, output, ROWS bits, meaning sticky per-row fault flags.
REQ-017 SHALL have port column_fault_detection, output, COLS bits, meaning per-column fault flags.

Function
REQ-018 SHALL implement FSM IDLE->CLEAR on start; CLEAR->SCAN after 1 cycle; SCAN->DONE after the PASSES*ROWS-th accepted beat; DONE->IDLE after 1 cycle.
REQ-019 SHALL ignore start outside IDLE; abort in CLEAR or SCAN SHALL return to IDLE next cycle, clear loops and results, and suppress done.
REQ-020 SHALL, in CLEAR, zero all loop stages, row_fault_detection, column_fault_detection and row_idx.
REQ-021 SHALL drive col_ready=1 only in SCAN with abort low; a beat is accepted iff col_valid&&col_ready; no beat means the loops and counters hold.
REQ-022 SHALL, per accepted beat, load stage0[c] <= col_inputs[c]|stage[ROWS-1][c] and shift stage[k] <= stage[k-1].
REQ-023 SHALL advance row_idx per accepted beat, wrapping ROWS-1->0; the beat counter SHALL saturate at PASSES*ROWS.
REQ-024 SHALL set row_fault_detection[row_idx] on an accepted beat whose single_pe_detection contains RUN_LEN adjacent ones (no wrap across column 0/COLS-1); bits are never cleared except by CLEAR, abort or reset.
REQ-025 SHALL register column_fault_detection[c] on the SCAN->DONE transition: 1 iff column c loop holds RUN_LEN consecutive ones among stages 0..ROWS-1, evaluated on the post-beat loop contents with no wrap.
REQ-026 SHALL assert done during the DONE state only; results SHALL hold from DONE until the next CLEAR.
REQ-027 SHALL resolve start and abort in the same cycle in IDLE as start; in SCAN, abort SHALL win over a same-cycle final beat.

Reset
REQ-028 SHALL on rst_n low: FSM=IDLE, all loop stages, row_idx, counters, row/column fault outputs, busy and done = 0; col_ready=0; single_pe_detection = col_inputs.

Configuration
REQ-029 SHALL, with macro DIAG_FAULT_COUNT_EN defined, add output fault_count [clog2(ROWS*COLS+1)-1:0], registered at SCAN->DONE as the popcount of all loop stages, reset/CLEAR to 0; without the macro the port and logic SHALL be absent and all other behaviour SHALL be identical.

Verification (ROWS=COLS=8, RUN_LEN=3, PASSES=1)
REQ-030 SHALL check a clean run: start, 8 beats of 0x00 -> done pulse on the cycle after the 8th beat, all fault outputs 0, row_idx back at 0.
REQ-031 SHALL check a row fault: beat 5 = 0x38, others 0 -> row_fault_detection=0x20, column_fault_detection=0x00.
REQ-032 SHALL check a column fault: beats 2,3,4 = 0x01 -> column_fault_detection=0x01, row_fault_detection=0x00; beats 2,4 only -> 0x00.
REQ-033 SHALL check a stall plus abort: col_valid low for 3 cycles mid-scan -> row_idx holds; abort at beat 6 -> busy low next cycle, no done, outputs 0.
REQ-034 SHALL check reset mid-SCAN: rst_n low at beat 4 -> all outputs at reset values; start ignored while busy; fault_count=3 for the column-fault case when DIAG_FAULT_COUNT_EN is defined.
